// File: rtl/fir_tdm_scheduler.sv
// Time-division controller for one shared 3-tap FIR multiplier serving NUM_CH streams.
// Round-robin grant, per-channel 2-deep history, programmable coefficients, tagged results.
module fir_tdm_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DW     = 8,
  parameter int CW     = 8,
  parameter int OW     = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           s_valid,
  output logic [NUM_CH-1:0]           s_ready,
  input  logic [NUM_CH*DW-1:0]        s_data,
  input  logic                        cfg_we,
  input  logic [1:0]                  cfg_addr,
  input  logic signed [CW-1:0]        cfg_data,
  output logic                        cfg_ready,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [OW-1:0]        m_data,
  output logic [$clog2(NUM_CH)-1:0]   m_chan,
  output logic                        busy
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int PW  = DW + CW;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC0 = 3'd1,
    ST_MAC1 = 3'd2,
    ST_MAC2 = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  state_e                state_r;
  state_e                state_nxt_s;
  logic signed [CW-1:0]  coef_r [3];
  logic signed [DW-1:0]  h1_r [NUM_CH];
  logic signed [DW-1:0]  h2_r [NUM_CH];
  logic signed [DW-1:0]  s_arr_s [NUM_CH];
  logic signed [DW-1:0]  x_r;
  logic [CHW-1:0]        g_r;
  logic [CHW-1:0]        rr_ptr_r;
  logic signed [OW-1:0]  acc_r;
  logic signed [OW-1:0]  acc_nxt_s;
  logic                  grant_found_s;
  logic [CHW-1:0]        grant_idx_s;
  logic [CHW-1:0]        cand_s;
  logic                  cfg_wr_s;
  logic                  take_s;
  logic                  out_done_s;
  logic signed [CW-1:0]  mul_a_s;
  logic signed [DW-1:0]  mul_b_s;
  logic signed [PW-1:0]  mul_a_ext_s;
  logic signed [PW-1:0]  mul_b_ext_s;
  logic signed [PW-1:0]  prod_s;
  logic signed [OW-1:0]  prod_ext_s;

  // Widen a full-precision product to the accumulator width, preserving sign.
  function automatic logic signed [OW-1:0] sext_prod(input logic signed [PW-1:0] p);
    sext_prod = {{(OW-PW){p[PW-1]}}, p};
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign s_arr_s[i] = s_data[i*DW +: DW];
  end

  // Round-robin search for the first requester at or above rr_ptr, with wrap.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_s = CHW'((int'(rr_ptr_r) + k) % NUM_CH);
      if (!grant_found_s && s_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Next-state and handshake decode; configuration wins over a data grant in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    s_ready     = '0;
    cfg_wr_s    = 1'b0;
    take_s      = 1'b0;
    out_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_we) begin
          cfg_wr_s = 1'b1;
        end else if (grant_found_s) begin
          s_ready[grant_idx_s] = 1'b1;
          take_s      = 1'b1;
          state_nxt_s = ST_MAC0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MAC0: state_nxt_s = ST_MAC1;
      ST_MAC1: state_nxt_s = ST_MAC2;
      ST_MAC2: state_nxt_s = ST_OUT;
      ST_OUT: begin
        if (m_ready) begin
          out_done_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand select for the single shared multiplier and the accumulator update.
  always_comb begin
    mul_a_s   = '0;
    mul_b_s   = '0;
    acc_nxt_s = acc_r;
    case (state_r)
      ST_MAC0: begin
        mul_a_s = coef_r[0];
        mul_b_s = x_r;
      end
      ST_MAC1: begin
        mul_a_s = coef_r[1];
        mul_b_s = h1_r[g_r];
      end
      ST_MAC2: begin
        mul_a_s = coef_r[2];
        mul_b_s = h2_r[g_r];
      end
      default: begin
        mul_a_s = '0;
        mul_b_s = '0;
      end
    endcase
    mul_a_ext_s = {{DW{mul_a_s[CW-1]}}, mul_a_s};
    mul_b_ext_s = {{CW{mul_b_s[DW-1]}}, mul_b_s};
    prod_s      = mul_a_ext_s * mul_b_ext_s;
    prod_ext_s  = sext_prod(prod_s);
    case (state_r)
      ST_MAC0:          acc_nxt_s = prod_ext_s;
      ST_MAC1, ST_MAC2: acc_nxt_s = acc_r + prod_ext_s;
      default:          acc_nxt_s = acc_r;
    endcase
  end

  // State register with registered status flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      busy      <= (state_nxt_s != ST_IDLE);
      cfg_ready <= (state_nxt_s == ST_IDLE);
    end
  end

  // Datapath: coefficients, capture, accumulation, history shift and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_r[0] <= CW'(1);
      coef_r[1] <= CW'(2);
      coef_r[2] <= CW'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        h1_r[i] <= '0;
        h2_r[i] <= '0;
      end
      x_r      <= '0;
      g_r      <= '0;
      rr_ptr_r <= '0;
      acc_r    <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_chan   <= '0;
    end else begin
      if (cfg_wr_s) begin
        case (cfg_addr)
          2'd0:    coef_r[0] <= cfg_data;
          2'd1:    coef_r[1] <= cfg_data;
          2'd2:    coef_r[2] <= cfg_data;
          default: coef_r[0] <= coef_r[0];
        endcase
      end
      if (take_s) begin
        x_r <= s_arr_s[grant_idx_s];
        g_r <= grant_idx_s;
      end
      if (state_r == ST_MAC0 || state_r == ST_MAC1 || state_r == ST_MAC2) begin
        acc_r <= acc_nxt_s;
      end
      // History only advances once the granted sample's result is committed.
      if (state_r == ST_MAC2) begin
        h2_r[g_r] <= h1_r[g_r];
        h1_r[g_r] <= x_r;
        m_data    <= acc_nxt_s;
        m_chan    <= g_r;
        m_valid   <= 1'b1;
      end
      if (out_done_s) begin
        m_valid  <= 1'b0;
        rr_ptr_r <= (g_r == LAST_CH) ? '0 : g_r + CHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Directed self-checking bench for fir_tdm_scheduler (4 channels, 8-bit data/coefs, 20-bit out).
module tb_fir_tdm_scheduler;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [3:0]         s_valid = 4'd0;
  logic [3:0]         s_ready;
  logic [31:0]        s_data = 32'd0;
  logic               cfg_we = 1'b0;
  logic [1:0]         cfg_addr = 2'd0;
  logic signed [7:0]  cfg_data = 8'sd0;
  logic               cfg_ready;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic signed [19:0] m_data;
  logic [1:0]         m_chan;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  fir_tdm_scheduler #(.NUM_CH(4), .DW(8), .CW(8), .OW(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    s_valid = 4'd0;
    cfg_we  = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_m_data", $signed(m_data), 0);
    check_val("rst_m_chan", m_chan, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_s_ready", s_ready, 0);
    check_val("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Offer one sample on one channel, then check grant, latency and the tagged result.
  task automatic send(input int ch, input logic signed [7:0] val, input int exp_data);
    int n;
    s_valid = 4'd0;
    s_valid[ch] = 1'b1;
    s_data[ch*8 +: 8] = val;
    #1;
    n = 0;
    while (!s_ready[ch] && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check_val("grant_timeout", (n < 100), 1);
    check_val("s_ready_onehot", s_ready, (1 << ch));
    @(negedge clk); #1;
    s_valid = 4'd0;
    n = 1;
    while (!m_valid && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check_val("latency", n, 4);
    check_val("m_data", $signed(m_data), exp_data);
    check_val("m_chan", m_chan, ch);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic signed [7:0] val);
    check_val("cfg_ready_idle", cfg_ready, 1);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = val;
    @(negedge clk); #1;
    cfg_we   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check_val("idle_timeout", (n < 100), 1);
  endtask

  initial begin
    int n;
    int last;
    @(negedge clk);
    apply_reset();

    // Default coefficients 1,2,1 on channel 0.
    send(0, 8'sd10, 10);
    send(0, 8'sd0, 20);
    send(0, 8'sd0, 10);
    send(0, 8'sd0, 0);

    // Interleaved channels keep separate histories.
    send(1, 8'sd10, 10);
    send(2, 8'sd5, 5);
    send(1, 8'sd0, 20);
    send(2, 8'sd5, 15);
    send(1, 8'sd0, 10);
    send(2, 8'sd5, 20);
    send(2, 8'sd5, 20);
    wait_idle();

    // Round-robin order and 5-cycle spacing from a fresh pointer.
    @(negedge clk);
    apply_reset();
    s_data  = 32'd0;
    s_valid = 4'hF;
    #1;
    last = 0;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (s_ready == 4'd0 && n < 50) begin
        @(negedge clk); #1; n++;
      end
      check_val("rr_timeout", (n < 50), 1);
      check_val("rr_order", s_ready, (1 << (i % 4)));
      if (i > 0) check_val("rr_spacing", cyc - last, 5);
      last = cyc;
      @(negedge clk); #1;
    end
    s_valid = 4'd0;
    wait_idle();

    // Programmed coefficients.
    cfg_write(2'd0, -8'sd3);
    cfg_write(2'd1, 8'sd4);
    cfg_write(2'd2, 8'sd0);
    send(3, 8'sd10, -30);
    send(3, 8'sd0, 40);
    send(3, 8'sd0, 0);
    wait_idle();
    cfg_write(2'd0, -8'sd128);
    cfg_write(2'd1, -8'sd128);
    cfg_write(2'd2, -8'sd128);
    send(3, -8'sd128, 16384);
    send(3, -8'sd128, 32768);
    send(3, -8'sd128, 49152);
    wait_idle();

    // Writes while busy are dropped.
    s_data[7:0] = 8'sd1;
    s_valid = 4'b0001;
    #1;
    n = 0;
    while (!s_ready[0] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check_val("busycfg_grant", (n < 50), 1);
    @(negedge clk); #1;
    s_valid  = 4'd0;
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = 8'sd5;
    #1;
    check_val("busycfg_busy", busy, 1);
    check_val("busycfg_cfg_ready", cfg_ready, 0);
    n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk); #1; n++;
    end
    cfg_we = 1'b0;
    check_val("busycfg_m_data", $signed(m_data), -128);
    send(0, 8'sd2, -384);
    wait_idle();

    // Back-pressure with every channel requesting.
    m_ready = 1'b0;
    s_data  = 32'h0003_0300;
    s_valid = 4'hF;
    #1;
    n = 0;
    while (s_ready == 4'd0 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check_val("bp_grant", s_ready, 4'b0010);
    n = 0;
    @(negedge clk); #1;
    while (!m_valid && n < 50) begin
      @(negedge clk); #1; n++;
    end
    for (int i = 0; i < 10; i++) begin
      check_val("bp_m_valid", m_valid, 1);
      check_val("bp_m_data", $signed(m_data), -384);
      check_val("bp_m_chan", m_chan, 1);
      check_val("bp_s_ready", s_ready, 0);
      check_val("bp_cfg_ready", cfg_ready, 0);
      @(negedge clk); #1;
    end
    m_ready = 1'b1;
    @(negedge clk); #1;
    check_val("bp_resume", s_ready, 4'b0100);
    @(negedge clk); #1;
    s_valid = 4'd0;
    n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check_val("bp_next_data", $signed(m_data), -384);
    check_val("bp_next_chan", m_chan, 2);
    wait_idle();

    // Reset in the middle of a computation.
    s_data[7:0] = 8'sd7;
    s_valid = 4'b0001;
    #1;
    n = 0;
    while (!s_ready[0] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk); #1;
    s_valid = 4'd0;
    @(negedge clk); #1;
    check_val("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_m_valid", m_valid, 0);
    check_val("mid_busy_rst", busy, 0);
    check_val("mid_cfg_ready", cfg_ready, 1);
    check_val("mid_m_data", $signed(m_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    send(0, 8'sd10, 10);
    send(0, 8'sd0, 20);
    send(0, 8'sd0, 10);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
